// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU controls, forward selects, multiplier FSM states.
package ex_stage_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b011;

    localparam logic [1:0] FW_REG    = 2'b00;
    localparam logic [1:0] FW_MEM_WB = 2'b01;
    localparam logic [1:0] FW_EX_MEM = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ex_stage_seq_multiplier.sv
// Fixed-latency shift-add multiplier: one iteration per BUSY cycle, result held for the single DONE cycle.
module seq_multiplier
    import ex_stage_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output state_t           state_o
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] prod_q, prod_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // No early exit on a zero multiplier: latency stays fixed.
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    assign busy    = (state_q == S_BUSY);
    assign done    = (state_q == S_DONE);
    assign product = prod_q;
    assign state_o = state_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, and a stalling sequential multiply.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [2:0]       ALUCtrl,
    input  logic             ALUSrc,
    input  logic [1:0]       ForwardA,
    input  logic [1:0]       ForwardB,
    input  logic [WIDTH-1:0] RsData,
    input  logic [WIDTH-1:0] RtData,
    input  logic [WIDTH-1:0] Imm,
    input  logic [WIDTH-1:0] EX_MEM_ALUResult,
    input  logic [WIDTH-1:0] MEM_WB_WriteData,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [WIDTH-1:0] WriteData,
    output logic             result_valid,
    output logic             Stall
);

    logic [WIDTH-1:0] op_a, fwd_b, op_b, alu_res, mul_product;
    logic             mul_busy, mul_done, mul_idle, mul_issue, live;
    state_t           mul_state;

    always_comb begin
        case (ForwardA)
            FW_EX_MEM: op_a = EX_MEM_ALUResult;
            FW_MEM_WB: op_a = MEM_WB_WriteData;
            default:   op_a = RsData;
        endcase
        case (ForwardB)
            FW_EX_MEM: fwd_b = EX_MEM_ALUResult;
            FW_MEM_WB: fwd_b = MEM_WB_WriteData;
            default:   fwd_b = RtData;
        endcase
        op_b = ALUSrc ? Imm : fwd_b;
    end

    assign WriteData = fwd_b;

    always_comb begin
        case (ALUCtrl)
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            default: alu_res = '0;
        endcase
    end

    // rst_n gates the outputs so nothing leaks out while reset is asserted.
    assign live      = rst_n & valid_i & ~flush_i;
    assign mul_idle  = (mul_state == S_IDLE);
    assign mul_issue = live & mul_idle & (ALUCtrl == ALU_MUL);

    seq_multiplier #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_issue),
        .flush   (flush_i),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product),
        .state_o (mul_state)
    );

    // The frozen MUL still sits in ID/EX during DONE; it is consumed there, not re-issued.
    always_comb begin
        ALU_Result   = '0;
        result_valid = 1'b0;
        Stall        = mul_busy | mul_issue;
        if (mul_done && !flush_i) begin
            ALU_Result   = mul_product;
            result_valid = 1'b1;
        end else if (mul_idle && live && ALUCtrl != ALU_MUL) begin
            ALU_Result   = alu_res;
            result_valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: driver tasks push expected results, a monitor pops them on result_valid.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i, flush_i, ALUSrc;
    logic [2:0]   ALUCtrl;
    logic [1:0]   ForwardA, ForwardB;
    logic [W-1:0] RsData, RtData, Imm, EX_MEM_ALUResult, MEM_WB_WriteData;
    logic [W-1:0] ALU_Result, WriteData;
    logic         result_valid, Stall;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    ex_stage #(.WIDTH(W), .MUL_CYCLES(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_i          (valid_i),
        .flush_i          (flush_i),
        .ALUCtrl          (ALUCtrl),
        .ALUSrc           (ALUSrc),
        .ForwardA         (ForwardA),
        .ForwardB         (ForwardB),
        .RsData           (RsData),
        .RtData           (RtData),
        .Imm              (Imm),
        .EX_MEM_ALUResult (EX_MEM_ALUResult),
        .MEM_WB_WriteData (MEM_WB_WriteData),
        .ALU_Result       (ALU_Result),
        .WriteData        (WriteData),
        .result_valid     (result_valid),
        .Stall            (Stall)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (result_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got valid result 0x%08h expected no result", ALU_Result);
            end else begin
                check("alu_result", ALU_Result, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic set_op(input logic [2:0] ctrl, input logic [1:0] fa, input logic [1:0] fb,
                          input logic src, input logic [W-1:0] rs, input logic [W-1:0] rt,
                          input logic [W-1:0] imm, input logic [W-1:0] exm, input logic [W-1:0] mwb);
        valid_i = 1'b1; flush_i = 1'b0;
        ALUCtrl = ctrl; ForwardA = fa; ForwardB = fb; ALUSrc = src;
        RsData = rs; RtData = rt; Imm = imm;
        EX_MEM_ALUResult = exm; MEM_WB_WriteData = mwb;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
    endtask

    // Issue one combinational op, expect its result and store data in the same cycle.
    task automatic alu_op(input string name, input logic [2:0] ctrl, input logic [1:0] fa,
                          input logic [1:0] fb, input logic src, input logic [W-1:0] rs,
                          input logic [W-1:0] rt, input logic [W-1:0] imm, input logic [W-1:0] exm,
                          input logic [W-1:0] mwb, input logic [W-1:0] exp_res, input logic [W-1:0] exp_wd);
        @(posedge clk); #1;
        set_op(ctrl, fa, fb, src, rs, rt, imm, exm, mwb);
        exp_q.push_back(exp_res);
        @(negedge clk);
        check({name, "_wdata"}, WriteData, exp_wd);
        check({name, "_stall"}, {31'd0, Stall}, 32'd0);
    endtask

    // A comes from EX/MEM, B from MEM/WB or Imm; forward sources are rewritten during BUSY.
    task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic use_imm, input logic [W-1:0] exp_res);
        int stalls;
        @(posedge clk); #1;
        if (use_imm) set_op(ALU_MUL, FW_EX_MEM, FW_MEM_WB, 1'b1, 32'h11, 32'h22, b, a, 32'hDEAD_BEEF);
        else         set_op(ALU_MUL, FW_EX_MEM, FW_MEM_WB, 1'b0, 32'h11, 32'h22, 32'h33, a, b);
        exp_q.push_back(exp_res);
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Stall !== 1'b1) break;
            stalls++;
            if (stalls == 5) begin
                EX_MEM_ALUResult = 32'h0000_1234;
                MEM_WB_WriteData = 32'h0000_5678;
            end
        end
        check({name, "_stall_cycles"}, W'(stalls), 32'd33);
        check({name, "_valid"}, {31'd0, result_valid}, 32'd1);
        idle_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        set_op(ALU_AND, FW_REG, FW_REG, 1'b0, '0, '0, '0, '0, '0);
        valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", {31'd0, Stall}, 32'd0);
        check("reset_valid", {31'd0, result_valid}, 32'd0);
        check("reset_result", ALU_Result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Forwarding
        alu_op("fwd_exmem_memwb", ALU_ADD, FW_EX_MEM, FW_MEM_WB, 1'b0, 32'd5, 32'd3, 32'd0, 32'd7, 32'd9, 32'd16, 32'd9);
        alu_op("fwd_11_as_reg",   ALU_ADD, 2'b11,     FW_REG,    1'b0, 32'd5, 32'd3, 32'd0, 32'd7, 32'd9, 32'd8,  32'd3);

        // ALU ops with immediate operand B
        alu_op("and_imm", ALU_AND, FW_REG, FW_REG, 1'b1, 32'h0000_000F, 32'd3, 32'hFFFF_FFF0, 32'd7, 32'd9, 32'h0000_0000, 32'd3);
        alu_op("or_imm",  ALU_OR,  FW_REG, FW_REG, 1'b1, 32'h0000_000F, 32'd3, 32'hFFFF_FFF0, 32'd7, 32'd9, 32'hFFFF_FFFF, 32'd3);
        alu_op("add_imm", ALU_ADD, FW_REG, FW_REG, 1'b1, 32'h0000_000F, 32'd3, 32'hFFFF_FFF0, 32'd7, 32'd9, 32'hFFFF_FFFF, 32'd3);
        alu_op("sub_imm", ALU_SUB, FW_REG, FW_REG, 1'b1, 32'h0000_000F, 32'd3, 32'hFFFF_FFF0, 32'd7, 32'd9, 32'h0000_001F, 32'd3);
        alu_op("undef_op", 3'b111, FW_REG, FW_REG, 1'b1, 32'h0000_000F, 32'd3, 32'hFFFF_FFF0, 32'd7, 32'd9, 32'h0000_0000, 32'd3);
        alu_op("fwd_b_wdata_imm", ALU_OR, FW_REG, FW_EX_MEM, 1'b1, 32'h0000_0100, 32'd3, 32'h0000_0001, 32'h55, 32'd9, 32'h0000_0101, 32'h55);
        idle_cycle();

        // Multiplies
        run_mul("mul_basic", 32'h0001_0003, 32'h0001_0002, 1'b0, 32'h0005_0006);
        run_mul("mul_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001);
        run_mul("mul_zero",  32'h0000_0000, 32'd123,       1'b0, 32'h0000_0000);

        // Flush and issue together: flush wins
        @(posedge clk); #1;
        set_op(ALU_MUL, FW_REG, FW_REG, 1'b0, 32'd5, 32'd6, 32'd0, 32'd0, 32'd0);
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_issue_stall", {31'd0, Stall}, 32'd0);
        idle_cycle();
        @(negedge clk);
        check("flush_issue_no_busy", {31'd0, Stall}, 32'd0);

        // Flush at BUSY cycle 10
        @(posedge clk); #1;
        set_op(ALU_MUL, FW_REG, FW_REG, 1'b0, 32'd5, 32'd6, 32'd0, 32'd0, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        idle_cycle();
        @(negedge clk);
        check("flush_stall_next", {31'd0, Stall}, 32'd0);
        alu_op("add_after_flush", ALU_ADD, FW_REG, FW_REG, 1'b0, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd4, 32'd2);
        idle_cycle();
        repeat (3) idle_cycle();

        // Reset mid-multiply
        @(posedge clk); #1;
        set_op(ALU_MUL, FW_REG, FW_REG, 1'b0, 32'd7, 32'd9, 32'd0, 32'd0, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", {31'd0, Stall}, 32'd0);
        check("rst_mid_valid", {31'd0, result_valid}, 32'd0);
        check("rst_mid_result", ALU_Result, 32'd0);
        idle_cycle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_mul("mul_after_reset", 32'd3, 32'd4, 1'b0, 32'd12);

        repeat (3) idle_cycle();
        check("queue_drained", W'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
